// File: rtl/fft_band_pkg.sv
// Shared constants, band table, state encoding and helpers for the FFT band controller.
package fft_band_pkg;

    localparam int unsigned NUM_BANDS = 16;
    localparam int unsigned FFT_N     = 1024;
    localparam int unsigned LVL_W     = 4;

    // Inclusive upper bin index of each log-spaced band; band 0 starts at bin 1.
    localparam logic [9:0] BAND_UB [NUM_BANDS] = '{
        10'd2,   10'd4,   10'd6,   10'd9,
        10'd13,  10'd18,  10'd25,  10'd35,
        10'd49,  10'd68,  10'd95,  10'd132,
        10'd183, 10'd254, 10'd354, 10'd511
    };

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SKIP,
        COMMIT
    } state_t;

    // Unsigned 64-bit add that clamps to all-ones instead of wrapping.
    function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
    endfunction

endpackage

// File: rtl/fft_band_ctrl_band_level_calc.sv
// Maps a 64-bit band energy sum to a bar height: msb position minus a log floor, clamped.
module band_level_calc
    import fft_band_pkg::*;
#(
    parameter int unsigned MAX_LEVEL = 8,
    parameter int unsigned LOG_FLOOR = 20
)(
    input  logic [63:0]      acc,
    output logic [LVL_W-1:0] lvl
);

    int unsigned pos1;

    // Priority-encode the highest set bit (as position+1, 0 for an all-zero sum) and clamp.
    always_comb begin
        pos1 = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (acc[i]) pos1 = i + 1;
        end
        if (pos1 <= LOG_FLOOR) begin
            lvl = '0;
        end else if (pos1 - LOG_FLOOR >= MAX_LEVEL) begin
            lvl = LVL_W'(MAX_LEVEL);
        end else begin
            lvl = LVL_W'(pos1 - LOG_FLOOR);
        end
    end

endmodule

// File: rtl/fft_band_ctrl.sv
// Frames the FFT magnitude stream, sums bins 1..511 into 16 bands, applies peak-hold decay
// and presents each finished frame to the display through a single output buffer.
module fft_band_ctrl
    import fft_band_pkg::*;
#(
    parameter int unsigned MAX_LEVEL = 8,
    parameter int unsigned LOG_FLOOR = 20,
    parameter int unsigned DROP_W    = 8
)(
    input  logic              data_in_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [10:0]       fft_data_cnt,
    input  logic [63:0]       fft_data_amp,
    output logic              frame_valid,
    input  logic              frame_ready,
    input  logic [3:0]        rd_band,
    output logic [3:0]        rd_level,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              sync_err
);

    state_t           state;
    logic [10:0]      exp_cnt;
    logic [63:0]      acc;
    logic [3:0]       band;
    logic [LVL_W-1:0] held     [NUM_BANDS];
    logic [LVL_W-1:0] work_buf [NUM_BANDS];
    logic [LVL_W-1:0] out_buf  [NUM_BANDS];

    logic [10:0]      bin;
    logic [63:0]      acc_incl;
    logic             band_end;
    logic             cnt_ok;
    logic             frame_start;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] held_cur;
    logic [LVL_W-1:0] new_held;
    logic             commit;
    logic             buf_free;

    band_level_calc #(
        .MAX_LEVEL (MAX_LEVEL),
        .LOG_FLOOR (LOG_FLOOR)
    ) u_level (
        .acc (acc_incl),
        .lvl (lvl)
    );

    // Per-cycle datapath terms: current bin, running sum including this bin, band boundary, decay.
    always_comb begin
        bin         = fft_data_cnt - 11'd1;
        acc_incl    = sat_add64(acc, fft_data_amp);
        band_end    = (bin == {1'b0, BAND_UB[band]});
        cnt_ok      = (fft_data_cnt == exp_cnt);
        frame_start = enable && (fft_data_cnt == 11'd1);
        held_cur    = held[band];
        new_held    = (lvl >= held_cur) ? lvl : held_cur - LVL_W'(1);
        commit      = (state == COMMIT);
        buf_free    = !frame_valid || frame_ready;
    end

    // Frame capture FSM: accumulate bands, update peak-hold and work buffer, watch continuity.
    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            exp_cnt  <= '0;
            acc      <= '0;
            band     <= '0;
            sync_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                held[i]     <= '0;
                work_buf[i] <= '0;
            end
        end else begin
            exp_cnt <= exp_cnt + 11'd1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= ACC;
                        exp_cnt <= 11'd2;
                        acc     <= '0;
                        band    <= '0;
                    end
                end
                ACC: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!cnt_ok) begin
                        sync_err <= 1'b1;
                        state    <= IDLE;
                    end else if (band_end) begin
                        held[band]     <= new_held;
                        work_buf[band] <= new_held;
                        acc            <= '0;
                        band           <= band + 4'd1;
                        if (band == 4'(NUM_BANDS - 1)) state <= SKIP;
                    end else begin
                        acc <= acc_incl;
                    end
                end
                SKIP: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!cnt_ok) begin
                        sync_err <= 1'b1;
                        state    <= IDLE;
                    end else if (fft_data_cnt == 11'(FFT_N)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // The commit cycle coincides with cnt==1 of a back-to-back frame.
                    if (frame_start) begin
                        state   <= ACC;
                        exp_cnt <= 11'd2;
                        acc     <= '0;
                        band    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output side: load or drop the finished frame, run the valid/ready handshake, serve reads.
    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            drop_cnt    <= '0;
            rd_level    <= '0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                out_buf[i] <= '0;
            end
        end else begin
            rd_level <= out_buf[rd_band];
            if (commit && buf_free) begin
                out_buf     <= work_buf;
                frame_valid <= 1'b1;
            end else begin
                if (frame_valid && frame_ready) frame_valid <= 1'b0;
                if (commit && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_band_ctrl.sv
// Directed self-checking bench for fft_band_ctrl.
module tb_fft_band_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] fft_data_cnt;
    logic [63:0] fft_data_amp;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  rd_band;
    logic [3:0]  rd_level;
    logic [7:0]  drop_cnt;
    logic        sync_err;

    int total = 0;
    int bad   = 0;

    fft_band_ctrl #(
        .MAX_LEVEL (8),
        .LOG_FLOOR (20),
        .DROP_W    (8)
    ) dut (
        .data_in_clk  (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fft_data_cnt (fft_data_cnt),
        .fft_data_amp (fft_data_amp),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .rd_band      (rd_band),
        .rd_level     (rd_level),
        .drop_cnt     (drop_cnt),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: every bin 2^20; mode 1: bin 40 = 2^30, ignored bins loud, rest 0; mode 2: silence
    function automatic logic [63:0] amp_for(input int mode, input int c);
        if (mode == 0) return 64'd1 << 20;
        if (mode == 1) begin
            if (c == 41) return 64'd1 << 30;
            if (c == 1 || c >= 513) return 64'd1 << 40;
        end
        return 64'd0;
    endfunction

    task automatic send_range(input int mode, input int first, input int last, input int skip);
        for (int c = first; c <= last; c++) begin
            if (c != skip) begin
                fft_data_cnt = 11'(c);
                fft_data_amp = amp_for(mode, c);
                @(negedge clk);
            end
        end
        fft_data_cnt = '0;
        fft_data_amp = '0;
    endtask

    task automatic read_check(input string tag, input int b, input int exp);
        rd_band = 4'(b);
        @(negedge clk);
        check(tag, {60'd0, rd_level}, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        fft_data_cnt = '0;
        fft_data_amp = '0;
        frame_ready  = 1'b1;
        rd_band      = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", frame_valid, 0);
        check("rst_level", rd_level, 0);
        check("rst_drop",  drop_cnt, 0);
        check("rst_sync",  sync_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Uniform 2^20 per bin: level = floor(log2(bins in band)) + 1, 2-cycle commit latency
        send_range(0, 1, 1024, 0);
        check("lat_edge1", frame_valid, 0);
        @(negedge clk);
        check("lat_edge2", frame_valid, 1);
        @(negedge clk);
        check("valid_pulse", frame_valid, 0);
        read_check("u_band0", 0, 2);
        read_check("u_band3", 3, 2);
        read_check("u_band5", 5, 3);
        read_check("u_band7", 7, 4);
        read_check("u_band14", 14, 7);
        read_check("u_band15", 15, 8);

        // Single tone in band 8, then silence decays it one step per frame
        do_reset();
        send_range(1, 1, 1024, 0);
        repeat (2) @(negedge clk);
        read_check("tone_band8", 8, 8);
        read_check("tone_band7", 7, 0);
        read_check("tone_band9", 9, 0);
        read_check("tone_bin0_ignored", 0, 0);
        read_check("tone_hi_ignored", 15, 0);
        for (int k = 7; k >= 0; k--) begin
            send_range(2, 1, 1024, 0);
            repeat (2) @(negedge clk);
            read_check("decay_band8", 8, k);
        end

        // Back-pressure: three frames with display busy, first frame held, two dropped
        frame_ready = 1'b0;
        send_range(0, 1, 1024, 0);
        send_range(2, 1, 1024, 0);
        send_range(2, 1, 1024, 0);
        repeat (2) @(negedge clk);
        check("bp_valid", frame_valid, 1);
        check("bp_drop", drop_cnt, 2);
        read_check("bp_first_data", 0, 2);
        frame_ready = 1'b1;
        @(negedge clk);
        check("bp_release", frame_valid, 0);

        // Ready arriving exactly in the commit cycle reloads the buffer without a drop
        frame_ready = 1'b0;
        send_range(1, 1, 1024, 0);
        repeat (2) @(negedge clk);
        read_check("pre_reload_band8", 8, 8);
        send_range(2, 1, 1024, 0);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check("reload_valid", frame_valid, 1);
        check("reload_drop", drop_cnt, 2);
        read_check("reload_band8", 8, 7);
        frame_ready = 1'b1;
        @(negedge clk);
        check("reload_clear", frame_valid, 0);

        // Counter discontinuity 100 -> 102 aborts the frame; next clean frame commits
        send_range(0, 1, 1024, 101);
        repeat (2) @(negedge clk);
        check("sync_err_set", sync_err, 1);
        check("sync_no_commit", frame_valid, 0);
        frame_ready = 1'b0;
        send_range(0, 1, 1024, 0);
        @(negedge clk);
        check("sync_recover_valid", frame_valid, 1);
        check("sync_sticky", sync_err, 1);
        read_check("sync_band0", 0, 2);
        read_check("sync_band8", 8, 5);
        read_check("sync_band15", 15, 8);

        // Asynchronous reset mid-frame at cnt 300
        rd_band = 4'd0;
        send_range(0, 1, 299, 0);
        rst_n = 1'b0;
        #1;
        check("amid_valid", frame_valid, 0);
        check("amid_level", rd_level, 0);
        check("amid_drop", drop_cnt, 0);
        check("amid_sync", sync_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_ready = 1'b1;
        send_range(0, 300, 1024, 0);
        @(negedge clk);
        check("amid_no_partial", frame_valid, 0);
        send_range(0, 1, 1024, 0);
        @(negedge clk);
        check("amid_resume_valid", frame_valid, 1);
        read_check("amid_band0", 0, 2);
        read_check("amid_band8", 8, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
